// File: rtl/atm_pin_entry_ctrl.sv
// PIN-entry and verification controller.
// Collects BCD digits from a one-hot keypad, checks them against the card's
// stored PIN, counts consecutive failures up to a lockout limit and enforces
// an inactivity timeout while the customer is typing.
module atm_pin_entry_ctrl #(
  parameter  int PIN_DIGITS = 4,
  parameter  int MAX_TRIES  = 3,
  parameter  int T_WIDTH    = 32,
  localparam int P_WIDTH    = 4 * PIN_DIGITS,
  localparam int CW         = $clog2(PIN_DIGITS + 1),
  localparam int EW         = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [P_WIDTH-1:0] user_pin,
  input  logic [9:0]         digit_buttons,
  input  logic               enter_button,
  input  logic               clear_button,
  input  logic               cancel_button,
  input  logic               unlock,
  input  logic [T_WIDTH-1:0] threshold,
  output logic               pin_ok,
  output logic               wrong_password,
  output logic               time_out,
  output logic               cancelled,
  output logic               locked,
  output logic               busy,
  output logic [CW-1:0]      digit_count,
  output logic [EW-1:0]      tries_left
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_LOCKED
  } state_t;

  state_t             state_q, state_nx;
  logic [P_WIDTH-1:0] buf_q, buf_nx;
  logic [CW-1:0]      cnt_q, cnt_nx;
  logic [T_WIDTH-1:0] timer_q, timer_nx;
  logic [EW-1:0]      err_q, err_nx;
  logic               pin_ok_q, pin_ok_nx;
  logic               wrong_q, wrong_nx;
  logic               tout_q, tout_nx;
  logic               cancel_q, cancel_nx;

  // Keypad sampling: _p0 is the registered button, _p1 the value one cycle older
  logic [9:0] dig_p0, dig_p1;
  logic       ent_p0, ent_p1;
  logic       clr_p0, clr_p1;
  logic       can_p0, can_p1;

  logic       dig_ev, ent_ev, clr_ev, can_ev;
  logic [3:0] dig_val;
  logic       timeout_hit;
  logic       pin_match;

  // Button registers for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_p0 <= '0;
      dig_p1 <= '0;
      ent_p0 <= 1'b0;
      ent_p1 <= 1'b0;
      clr_p0 <= 1'b0;
      clr_p1 <= 1'b0;
      can_p0 <= 1'b0;
      can_p1 <= 1'b0;
    end else begin
      dig_p0 <= digit_buttons;
      dig_p1 <= dig_p0;
      ent_p0 <= enter_button;
      ent_p1 <= ent_p0;
      clr_p0 <= clear_button;
      clr_p1 <= clr_p0;
      can_p0 <= cancel_button;
      can_p1 <= can_p0;
    end
  end

  // A digit only counts when it comes from an all-released keypad and exactly one key is down
  assign dig_ev = $onehot(dig_p0) && (dig_p1 == '0);
  assign ent_ev = ent_p0 & ~ent_p1;
  assign clr_ev = clr_p0 & ~clr_p1;
  assign can_ev = can_p0 & ~can_p1;

  assign timeout_hit = (threshold != '0) && (timer_q == threshold - T_WIDTH'(1));
  assign pin_match   = (buf_q == user_pin) && (cnt_q == CW'(PIN_DIGITS));

  // One-hot keypad to BCD digit
  always_comb begin
    dig_val = '0;
    for (int k = 0; k < 10; k++) begin
      if (dig_p0[k]) dig_val = 4'(k);
    end
  end

  // Next-state, datapath and result-pulse logic
  always_comb begin
    state_nx  = state_q;
    buf_nx    = buf_q;
    cnt_nx    = cnt_q;
    timer_nx  = timer_q;
    err_nx    = err_q;
    pin_ok_nx = 1'b0;
    wrong_nx  = 1'b0;
    tout_nx   = 1'b0;
    cancel_nx = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ENTRY;
          buf_nx   = '0;
          cnt_nx   = '0;
          timer_nx = '0;
        end
      end
      S_ENTRY: begin
        timer_nx = timer_q + T_WIDTH'(1);
        if (can_ev) begin
          state_nx  = S_IDLE;
          cancel_nx = 1'b1;
          buf_nx    = '0;
          cnt_nx    = '0;
        end else if (timeout_hit) begin
          state_nx = S_IDLE;
          tout_nx  = 1'b1;
        end else if (ent_ev) begin
          state_nx = S_CHECK;
        end else if (clr_ev) begin
          timer_nx = '0;
          if (cnt_q != '0) begin
            buf_nx = buf_q >> 4;
            cnt_nx = cnt_q - CW'(1);
          end
        end else if (dig_ev && (cnt_q < CW'(PIN_DIGITS))) begin
          timer_nx = '0;
          buf_nx   = (buf_q << 4) | P_WIDTH'(dig_val);
          cnt_nx   = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (can_ev) begin
          state_nx  = S_IDLE;
          cancel_nx = 1'b1;
          buf_nx    = '0;
          cnt_nx    = '0;
        end else if (pin_match) begin
          state_nx  = S_IDLE;
          pin_ok_nx = 1'b1;
          err_nx    = '0;
        end else begin
          wrong_nx = 1'b1;
          err_nx   = err_q + EW'(1);
          if (err_q == EW'(MAX_TRIES - 1)) begin
            state_nx = S_LOCKED;
          end else begin
            state_nx = S_ENTRY;
            buf_nx   = '0;
            cnt_nx   = '0;
            timer_nx = '0;
          end
        end
      end
      S_LOCKED: begin
        if (unlock) begin
          state_nx = S_IDLE;
          err_nx   = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, buffer, timer, error count and result pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      err_q    <= '0;
      pin_ok_q <= 1'b0;
      wrong_q  <= 1'b0;
      tout_q   <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_nx;
      buf_q    <= buf_nx;
      cnt_q    <= cnt_nx;
      timer_q  <= timer_nx;
      err_q    <= err_nx;
      pin_ok_q <= pin_ok_nx;
      wrong_q  <= wrong_nx;
      tout_q   <= tout_nx;
      cancel_q <= cancel_nx;
    end
  end

  assign pin_ok         = pin_ok_q;
  assign wrong_password = wrong_q;
  assign time_out       = tout_q;
  assign cancelled      = cancel_q;
  assign locked         = (state_q == S_LOCKED);
  assign busy           = (state_q != S_IDLE);
  assign digit_count    = cnt_q;
  assign tries_left     = EW'(MAX_TRIES) - err_q;

endmodule

// File: tb/tb_atm_pin_entry_ctrl.sv
// Bench for atm_pin_entry_ctrl: directed scenarios plus randomized keypad
// traffic, checked every cycle against a behavioural session model.
module tb_atm_pin_entry_ctrl;

  localparam int PIN_DIGITS = 4;
  localparam int MAX_TRIES  = 3;
  localparam int T_WIDTH    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] user_pin = 16'h1234;
  logic [9:0]  digit_buttons = '0;
  logic        enter_button = 1'b0;
  logic        clear_button = 1'b0;
  logic        cancel_button = 1'b0;
  logic        unlock = 1'b0;
  logic [31:0] threshold = '0;
  logic        pin_ok, wrong_password, time_out, cancelled, locked, busy;
  logic [2:0]  digit_count;
  logic [1:0]  tries_left;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  atm_pin_entry_ctrl #(
    .PIN_DIGITS(PIN_DIGITS),
    .MAX_TRIES (MAX_TRIES),
    .T_WIDTH   (T_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .user_pin      (user_pin),
    .digit_buttons (digit_buttons),
    .enter_button  (enter_button),
    .clear_button  (clear_button),
    .cancel_button (cancel_button),
    .unlock        (unlock),
    .threshold     (threshold),
    .pin_ok        (pin_ok),
    .wrong_password(wrong_password),
    .time_out      (time_out),
    .cancelled     (cancelled),
    .locked        (locked),
    .busy          (busy),
    .digit_count   (digit_count),
    .tries_left    (tries_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural session model ----------------
  bit          m_typing, m_judging, m_lock;
  int          m_digits[$];
  int unsigned m_idle;
  int          m_fails;
  bit          e_pin, e_wrong, e_to, e_can;
  logic [9:0]  h1d, h2d;
  bit          h1e, h2e, h1c, h2c, h1x, h2x;

  task automatic model_reset();
    m_typing = 0; m_judging = 0; m_lock = 0;
    m_digits.delete();
    m_idle = 0; m_fails = 0;
    e_pin = 0; e_wrong = 0; e_to = 0; e_can = 0;
    h1d = '0; h2d = '0;
    h1e = 0; h2e = 0; h1c = 0; h2c = 0; h1x = 0; h2x = 0;
  endtask

  task automatic model_step();
    bit     ev_ent, ev_clr, ev_can, ev_dig;
    int     dv;
    longint val;
    ev_ent = h1e && !h2e;
    ev_clr = h1c && !h2c;
    ev_can = h1x && !h2x;
    ev_dig = ($countones(h1d) == 1) && (h2d == '0);
    dv = 0;
    for (int i = 0; i < 10; i++) if (h1d[i]) dv = i;
    e_pin = 0; e_wrong = 0; e_to = 0; e_can = 0;
    if (m_lock) begin
      if (unlock) begin
        m_lock = 0;
        m_fails = 0;
      end
    end else if (m_judging) begin
      m_judging = 0;
      val = 0;
      foreach (m_digits[i]) val = val * 16 + m_digits[i];
      if (ev_can) begin
        e_can = 1;
        m_digits.delete();
      end else if (m_digits.size() == PIN_DIGITS && val == longint'(user_pin)) begin
        e_pin = 1;
        m_fails = 0;
      end else begin
        e_wrong = 1;
        m_fails++;
        if (m_fails == MAX_TRIES) m_lock = 1;
        else begin
          m_typing = 1;
          m_digits.delete();
          m_idle = 0;
        end
      end
    end else if (m_typing) begin
      m_idle++;
      if (ev_can) begin
        m_typing = 0; e_can = 1; m_digits.delete();
      end else if (threshold != 0 && m_idle == threshold) begin
        m_typing = 0; e_to = 1;
      end else if (ev_ent) begin
        m_typing = 0; m_judging = 1;
      end else if (ev_clr) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
        m_idle = 0;
      end else if (ev_dig && m_digits.size() < PIN_DIGITS) begin
        m_digits.push_back(dv);
        m_idle = 0;
      end
    end else if (start) begin
      m_typing = 1;
      m_digits.delete();
      m_idle = 0;
    end
    h2d = h1d; h1d = digit_buttons;
    h2e = h1e; h1e = enter_button;
    h2c = h1c; h1c = clear_button;
    h2x = h1x; h1x = cancel_button;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pin_ok", pin_ok, e_pin);
      chk("wrong_password", wrong_password, e_wrong);
      chk("time_out", time_out, e_to);
      chk("cancelled", cancelled, e_can);
      chk("locked", locked, m_lock);
      chk("busy", busy, m_typing | m_judging | m_lock);
      chk("tries_left", tries_left, MAX_TRIES - m_fails);
      if (m_typing | m_judging | m_lock) chk("digit_count", digit_count, m_digits.size());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press_digit(input int d);
    digit_buttons = 10'(1) << d;
    tick();
    digit_buttons = '0;
    tick();
  endtask

  task automatic press_enter();
    enter_button = 1; tick(); enter_button = 0; tick();
  endtask

  task automatic press_clear();
    clear_button = 1; tick(); clear_button = 0; tick();
  endtask

  task automatic press_cancel();
    cancel_button = 1; tick(); cancel_button = 0; tick();
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic count_cycles(input int n, output int np, output int nw, output int nt, output int nc);
    np = 0; nw = 0; nt = 0; nc = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      np += int'(pin_ok); nw += int'(wrong_password);
      nt += int'(time_out); nc += int'(cancelled);
    end
  endtask

  task automatic enter_1235();
    press_digit(1); press_digit(2); press_digit(3); press_digit(5);
    press_enter();
  endtask

  initial begin
    int np, nw, nt, nc, k;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_locked", locked, 0);
    chk("reset_tries", tries_left, 3);
    chk("reset_count", digit_count, 0);
    rst = 1;
    chk_en = 1;
    tick();

    // correct PIN
    pulse_start();
    press_digit(1); press_digit(2); press_digit(3); press_digit(4);
    press_enter();
    count_cycles(4, np, nw, nt, nc);
    chk("ok_pin_pulses", np, 1);
    chk("ok_wrong_pulses", nw, 0);
    chk("ok_busy", busy, 0);
    chk("ok_tries", tries_left, 3);

    // three wrong entries lock the card
    pulse_start();
    enter_1235();
    count_cycles(4, np, nw, nt, nc);
    chk("wrong1_pulses", nw, 1);
    chk("wrong1_tries", tries_left, 2);
    enter_1235();
    count_cycles(4, np, nw, nt, nc);
    chk("wrong2_pulses", nw, 1);
    chk("wrong2_tries", tries_left, 1);
    enter_1235();
    count_cycles(4, np, nw, nt, nc);
    chk("wrong3_pulses", nw, 1);
    chk("wrong3_tries", tries_left, 0);
    chk("wrong3_locked", locked, 1);
    pulse_start();
    tick();
    chk("locked_ignores_start", locked, 1);
    unlock = 1; tick(); unlock = 0; tick();
    chk("unlock_locked", locked, 0);
    chk("unlock_tries", tries_left, 3);
    chk("unlock_busy", busy, 0);

    // backspace and overflow digit
    pulse_start();
    press_digit(1); press_digit(2); press_digit(9);
    chk("bs_count3", digit_count, 3);
    press_clear();
    chk("bs_count2", digit_count, 2);
    press_digit(3); press_digit(4);
    chk("bs_count4", digit_count, 4);
    press_digit(7);
    chk("bs_full", digit_count, 4);
    press_enter();
    count_cycles(4, np, nw, nt, nc);
    chk("bs_pin_ok", np, 1);

    // inactivity timeout
    threshold = 15;
    pulse_start();
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (time_out) begin k = i; break; end
    end
    chk("timeout_cycle", k, 15);
    pulse_start();
    repeat (8) tick();
    press_digit(5);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (time_out) begin k = i; break; end
    end
    chk("timeout_after_digit", k, 15);
    threshold = 0;
    pulse_start();
    count_cycles(1000, np, nw, nt, nc);
    chk("no_timeout_pulses", nt, 0);
    chk("no_timeout_busy", busy, 1);
    press_cancel();
    chk("cancel_busy", busy, 0);

    // enter and cancel together
    pulse_start();
    press_digit(9);
    enter_button = 1; cancel_button = 1; tick();
    enter_button = 0; cancel_button = 0;
    count_cycles(4, np, nw, nt, nc);
    chk("ec_cancelled", nc, 1);
    chk("ec_wrong", nw, 0);
    chk("ec_tries", tries_left, 3);

    // multi-hot keypad
    pulse_start();
    digit_buttons = (10'(1) << 3) | (10'(1) << 5);
    tick();
    digit_buttons = '0;
    tick();
    chk("multihot_count", digit_count, 0);
    press_cancel();

    // reset mid-entry with two failures recorded
    pulse_start();
    enter_1235();
    count_cycles(4, np, nw, nt, nc);
    enter_1235();
    count_cycles(4, np, nw, nt, nc);
    chk("pre_reset_tries", tries_left, 1);
    press_digit(7);
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_tries", tries_left, 3);
    tick();
    rst = 1;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      if (c % 250 == 0) begin
        r = $urandom_range(0, 3);
        threshold = (r == 0) ? 0 : (r == 1) ? 3 : (r == 2) ? 8 : 20;
        user_pin = ($urandom_range(0, 1) == 0) ? 16'h1234 :
                   {4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)),
                    4'($urandom_range(1, 4)), 4'($urandom_range(1, 4))};
      end
      r = $urandom_range(0, 99);
      if (r < 55) digit_buttons = '0;
      else if (r < 80) digit_buttons = 10'(1) << $urandom_range(1, 4);
      else if (r < 93) digit_buttons = 10'(1) << $urandom_range(0, 9);
      else digit_buttons = 10'($urandom_range(0, 1023));
      enter_button  = ($urandom_range(0, 9) == 0);
      clear_button  = ($urandom_range(0, 11) == 0);
      cancel_button = ($urandom_range(0, 39) == 0);
      start         = ($urandom_range(0, 5) == 0);
      unlock        = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 0;
        tick();
        rst = 1;
      end else begin
        tick();
      end
    end
    start = 0; unlock = 0; digit_buttons = '0;
    enter_button = 0; clear_button = 0; cancel_button = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
